// File: rtl/l1mtx_input_stage.sv
// Per-master input stage of the L1 AHB bus matrix: passes address phases
// straight through, or holds one and stalls the master until it is accepted.
module l1mtx_input_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic [1:0]            HRESPS,
    output logic                  ACTIVE_TRANS,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    input  logic                  ACCEPT,
    input  logic                  DATA_PHASE,
    input  logic                  HREADYM,
    input  logic [1:0]            HRESPM
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            trans_q, trans_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [2:0]            burst_q, burst_d;
    logic [3:0]            prot_q, prot_d;

    logic new_tran;
    logic pend;
    logic load;

    assign new_tran = HSELS & HREADYS & HTRANSS[1];
    assign pend     = (state_q == ST_HOLD);
    assign load     = new_tran & ~pend;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            trans_q <= 2'b00;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            burst_q <= 3'b000;
            prot_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            trans_q <= trans_d;
            write_q <= write_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            prot_q  <= prot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (new_tran && !ACCEPT) state_d = ST_HOLD;
            ST_HOLD: if (ACCEPT) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture every live address phase; only used if the stage must hold it.
    always_comb begin
        addr_d  = addr_q;
        trans_d = trans_q;
        write_d = write_q;
        size_d  = size_q;
        burst_d = burst_q;
        prot_d  = prot_q;
        if (load) begin
            addr_d  = HADDRS;
            trans_d = HTRANSS;
            write_d = HWRITES;
            size_d  = HSIZES;
            burst_d = HBURSTS;
            prot_d  = HPROTS;
        end
    end

    always_comb begin
        HADDRM  = HADDRS;
        HTRANSM = HSELS ? HTRANSS : 2'b00;
        HWRITEM = HWRITES;
        HSIZEM  = HSIZES;
        HBURSTM = HBURSTS;
        HPROTM  = HPROTS;
        if (pend) begin
            HADDRM  = addr_q;
            HTRANSM = trans_q;
            HWRITEM = write_q;
            HSIZEM  = size_q;
            HBURSTM = burst_q;
            HPROTM  = prot_q;
        end
    end

    assign ACTIVE_TRANS = pend | (HSELS & HTRANSS[1]);
    assign HREADYOUTS   = DATA_PHASE ? HREADYM : ~pend;
    assign HRESPS       = DATA_PHASE ? HRESPM : 2'b00;

endmodule
